// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit that owns the HI/LO pair.
// Arithmetic ops run for a fixed number of cycles on latched operands,
// while mthi/mtlo writes and mfhi/mflo reads are single-cycle and idle-only.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Emdop,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] md_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [3:0] OP_MFHI = 4'b0100;
  localparam logic [3:0] OP_MFLO = 4'b0101;
  localparam logic [3:0] OP_MTHI = 4'b0110;
  localparam logic [3:0] OP_MTLO = 4'b0111;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic               is_arith_c;
  logic [63:0]        prod_c;
  logic [31:0]        abs_a_c;
  logic [31:0]        abs_b_c;
  logic [31:0]        quo_c;
  logic [31:0]        rem_c;
  logic [31:0]        res_hi_c;
  logic [31:0]        res_lo_c;
  logic               res_wr_c;

  // Arithmetic opcodes are 0000..0011: the two upper bits are clear.
  assign is_arith_c = (Emdop[3:2] == 2'b00);

  // Result of the latched operation; divide-by-zero leaves HI/LO untouched.
  always_comb begin
    prod_c   = '0;
    abs_a_c  = '0;
    abs_b_c  = '0;
    quo_c    = '0;
    rem_c    = '0;
    res_hi_c = '0;
    res_lo_c = '0;
    res_wr_c = 1'b0;
    case (op_q)
      2'b00: begin
        prod_c   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        res_hi_c = prod_c[63:32];
        res_lo_c = prod_c[31:0];
        res_wr_c = 1'b1;
      end
      2'b01: begin
        prod_c   = {32'd0, a_q} * {32'd0, b_q};
        res_hi_c = prod_c[63:32];
        res_lo_c = prod_c[31:0];
        res_wr_c = 1'b1;
      end
      2'b10: begin
        if (b_q != 32'd0) begin
          // Magnitude divide then re-sign; 0x80000000/-1 wraps to 0x80000000.
          abs_a_c  = a_q[31] ? 32'(-a_q) : a_q;
          abs_b_c  = b_q[31] ? 32'(-b_q) : b_q;
          quo_c    = abs_a_c / abs_b_c;
          rem_c    = abs_a_c % abs_b_c;
          res_lo_c = (a_q[31] ^ b_q[31]) ? 32'(-quo_c) : quo_c;
          res_hi_c = a_q[31] ? 32'(-rem_c) : rem_c;
          res_wr_c = 1'b1;
        end
      end
      default: begin
        if (b_q != 32'd0) begin
          quo_c    = a_q / b_q;
          rem_c    = a_q % b_q;
          res_lo_c = quo_c;
          res_hi_c = rem_c;
          res_wr_c = 1'b1;
        end
      end
    endcase
  end

  // Control FSM, cycle counter, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && is_arith_c) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            op_q    <= Emdop[1:0];
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= Emdop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (Emdop == OP_MTHI) begin
            hi_q <= A;
          end else if (Emdop == OP_MTLO) begin
            lo_q <= A;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (res_wr_c) begin
              hi_q <= res_hi_c;
              lo_q <= res_lo_c;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency stall request and mf read port.
  always_comb begin
    md_hazard = (start & is_arith_c) | busy_q;
    case (Emdop)
      OP_MFHI: md_out = hi_q;
      OP_MFLO: md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit against a HI/LO model.
module tb_md_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Emdop;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        md_hazard;
  logic [31:0] md_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .Emdop     (Emdop),
    .start     (start),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .md_hazard (md_hazard),
    .md_out    (md_out),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: apply an arithmetic op to the HI/LO model using plain arithmetic.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd2: if (b != 32'd0) begin lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); end
      default: if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
    endcase
  endtask

  task automatic check_hilo(input string name);
    checks++;
    if (HI !== hi_m || LO !== lo_m) begin
      failures++;
      $display("FAIL %s: HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, hi_m, lo_m);
    end
  endtask

  // Launch one arithmetic op, scramble operands, check busy length and result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int n;
    int exp_n;
    Emdop = op; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0; Emdop = 4'hF; A = $urandom; B = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
    exp_n = op[1] ? int'(DIV_N) : int'(MULT_N);
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, n, exp_n);
    end
    model_op(op, a, b);
    check_hilo(name);
  endtask

  task automatic mt_write(input logic hi_sel, input logic [31:0] v);
    Emdop = hi_sel ? 4'b0110 : 4'b0111; A = v; start = $urandom_range(0, 1);
    step();
    Emdop = 4'hF; start = 1'b0;
    if (hi_sel) hi_m = v; else lo_m = v;
  endtask

  task automatic test_reset();
    Emdop = 4'hF; start = 1'b0; A = '0; B = '0; reset = 1'b1;
    step(); step();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    checks++;
    if (busy !== 1'b0 || md_out !== 32'd0 || md_hazard !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs: busy=%b md_out=%h hz=%b expected 0 0 0", busy, md_out, md_hazard);
    end
    check_hilo("reset_hilo");
  endtask

  task automatic test_reads_hazard();
    mt_write(1'b1, 32'hCAFE_0001);
    mt_write(1'b0, 32'hBEEF_0002);
    check_hilo("mt_write");
    Emdop = 4'b0100; #1;
    checks++;
    if (md_out !== 32'hCAFE_0001) begin failures++; $display("FAIL mfhi: got %h expected %h", md_out, 32'hCAFE_0001); end
    Emdop = 4'b0101; #1;
    checks++;
    if (md_out !== 32'hBEEF_0002) begin failures++; $display("FAIL mflo: got %h expected %h", md_out, 32'hBEEF_0002); end
    Emdop = 4'b1000; #1;
    checks++;
    if (md_out !== 32'd0) begin failures++; $display("FAIL md_out_other: got %h expected 0", md_out); end
    start = 1'b1; Emdop = 4'b0110; #1;
    checks++;
    if (md_hazard !== 1'b0) begin failures++; $display("FAIL hazard_mt: got %b expected 0", md_hazard); end
    Emdop = 4'b0011; #1;
    checks++;
    if (md_hazard !== 1'b1) begin failures++; $display("FAIL hazard_start: got %b expected 1", md_hazard); end
    start = 1'b0; Emdop = 4'hF; #1;
  endtask

  task automatic test_directed_arith();
    run_op(4'd0, 32'hFFFF_FFFF, 32'd2, "mult");
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL mult_const: HI=%h LO=%h expected ffffffff fffffffe", HI, LO);
    end
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, "multu");
    checks++;
    if (HI !== 32'h1 || LO !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL multu_const: HI=%h LO=%h expected 00000001 fffffffe", HI, LO);
    end
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL div_neg_const: HI=%h LO=%h expected ffffffff fffffffd", HI, LO);
    end
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checks++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
      failures++; $display("FAIL div_ovf_const: HI=%h LO=%h expected 00000000 80000000", HI, LO);
    end
  endtask

  task automatic test_div_zero();
    mt_write(1'b1, 32'h11);
    mt_write(1'b0, 32'h22);
    run_op(4'd3, 32'd7, 32'd0, "divu_zero");
    Emdop = 4'b0100; #1;
    checks++;
    if (md_out !== 32'h11) begin failures++; $display("FAIL divu_zero_mfhi: got %h expected 11", md_out); end
    Emdop = 4'hF;
    run_op(4'd2, 32'h1234, 32'd0, "div_zero");
  endtask

  // mtlo and a new start during RUN must both be ignored.
  task automatic test_ignore_in_run();
    int n;
    int g;
    n = 0;
    Emdop = 4'd0; A = 32'd3; B = 32'd4; start = 1'b1;
    step();
    start = 1'b0; Emdop = 4'hF;
    if (busy === 1'b1) n++;
    Emdop = 4'b0111; A = 32'h55; #1;
    checks++;
    if (md_hazard !== 1'b1) begin failures++; $display("FAIL run_hazard: got %b expected 1", md_hazard); end
    step();
    if (busy === 1'b1) n++;
    Emdop = 4'b0011; start = 1'b1; A = 32'd7; B = 32'd0;
    step();
    if (busy === 1'b1) n++;
    start = 1'b0; Emdop = 4'hF;
    g = 0;
    while (busy === 1'b1 && g < 64) begin
      step();
      if (busy === 1'b1) n++;
      g++;
    end
    checks++;
    if (n != int'(MULT_N)) begin failures++; $display("FAIL ignore_busy_len: got %0d expected %0d", n, MULT_N); end
    model_op(4'd0, 32'd3, 32'd4);
    check_hilo("ignore_result");
  endtask

  // start on the completing edge is dropped; the next edge accepts it.
  task automatic test_back_to_back();
    int n;
    Emdop = 4'd0; A = 32'd5; B = 32'd6; start = 1'b1;
    step();
    start = 1'b0; Emdop = 4'hF;
    repeat (MULT_N - 1) step();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_last_cycle: busy=%b expected 1", busy); end
    Emdop = 4'd3; A = 32'd9; B = 32'd2; start = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || md_hazard !== 1'b1) begin
      failures++; $display("FAIL b2b_done_edge: busy=%b hz=%b expected 0 1", busy, md_hazard);
    end
    model_op(4'd0, 32'd5, 32'd6);
    check_hilo("b2b_first");
    step();
    start = 1'b0; Emdop = 4'hF;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      step();
    end
    checks++;
    if (n != int'(DIV_N)) begin failures++; $display("FAIL b2b_second_len: got %0d expected %0d", n, DIV_N); end
    model_op(4'd3, 32'd9, 32'd2);
    check_hilo("b2b_second");
  endtask

  task automatic test_reset_mid();
    mt_write(1'b1, 32'hAAAA);
    Emdop = 4'd2; A = 32'd100; B = 32'd3; start = 1'b1;
    step();
    start = 1'b0; Emdop = 4'hF;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    check_hilo("reset_mid_hilo");
    repeat (DIV_N + 4) step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_late_busy: got %b expected 0", busy); end
    check_hilo("reset_mid_late");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    int          r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 17));
        default: ;
      endcase
      if (r < 4) begin
        run_op(4'(r), a, b, "rand_arith");
      end else if (r < 6) begin
        mt_write(r == 4, a);
        check_hilo("rand_mt");
      end else begin
        Emdop = (r < 8) ? 4'b0100 : 4'b0101; start = $urandom_range(0, 1); A = a; #1;
        checks++;
        if (md_out !== ((r < 8) ? hi_m : lo_m)) begin
          failures++; $display("FAIL rand_mf: got %h expected %h", md_out, (r < 8) ? hi_m : lo_m);
        end
        step();
        start = 1'b0; Emdop = 4'hF;
        check_hilo("rand_mf_nostate");
      end
    end
  endtask

  initial begin
    test_reset();
    test_reads_hazard();
    test_directed_arith();
    test_div_zero();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
